// File: rtl/fa_serial_add.sv
// fa_serial_add: digit-serial adder, {co,s} = a + b + ci over WIDTH/DIGIT cycles, LSB first.
// Define FA_SERIAL_SUB_EN to add a `sub` port selecting a - b - ci (co=1 means no borrow).
module fa_serial_add #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
`ifdef FA_SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co
);
   localparam int K  = WIDTH / DIGIT;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("fa_serial_add: DIGIT must divide WIDTH exactly");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
   logic             c_q, c_d, co_q, co_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DIGIT:0]   dsum;
   logic             sub_w;

`ifdef FA_SERIAL_SUB_EN
   assign sub_w = sub;
`else
   assign sub_w = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      co_d    = co_q;
      dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
      if (state_q != RUN && start) begin
         a_d     = a;
         b_d     = sub_w ? ~b : b;
         c_d     = ci ^ sub_w;
         acc_d   = '0;
         cnt_d   = '0;
         state_d = RUN;
      end else if (state_q == RUN) begin
         // new digit enters at the MSB end so after K digits the sum is aligned
         acc_d = WIDTH'({dsum[DIGIT-1:0], acc_q} >> DIGIT);
         a_d   = a_q >> DIGIT;
         b_d   = b_q >> DIGIT;
         c_d   = dsum[DIGIT];
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(K - 1)) begin
            s_d     = acc_d;
            co_d    = dsum[DIGIT];
            state_d = DONE;
         end
      end else begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         acc_q   <= '0;
         cnt_q   <= '0;
         s_q     <= '0;
         co_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         co_q    <= co_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign s    = s_q;
   assign co   = co_q;
endmodule

// File: tb/tb_fa_serial_add.sv
// tb_fa_serial_add: directed checks of fa_serial_add at WIDTH/DIGIT = 1/1, 8/1 and 8/4.
module tb_fa_serial_add;
   logic       clk, rst_n;
   logic       start1, start8, start4;
   logic [0:0] a1, b1;
   logic       ci1, ci8, ci4;
   logic [7:0] a8, b8, a4, b4;
   logic       busy1, busy8, busy4, done1, done8, done4;
   logic [0:0] s1;
   logic [7:0] s8, s4;
   logic       co1, co8, co4;
`ifdef FA_SERIAL_SUB_EN
   logic       sub1, sub8, sub4;
`endif
   int n_cmp = 0;
   int n_err = 0;

   fa_serial_add #(.WIDTH(1), .DIGIT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .ci(ci1),
`ifdef FA_SERIAL_SUB_EN
      .sub(sub1),
`endif
      .busy(busy1), .done(done1), .s(s1), .co(co1));

   fa_serial_add #(.WIDTH(8), .DIGIT(1)) u8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .ci(ci8),
`ifdef FA_SERIAL_SUB_EN
      .sub(sub8),
`endif
      .busy(busy8), .done(done8), .s(s8), .co(co8));

   fa_serial_add #(.WIDTH(8), .DIGIT(4)) u4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .ci(ci4),
`ifdef FA_SERIAL_SUB_EN
      .sub(sub4),
`endif
      .busy(busy4), .done(done4), .s(s4), .co(co4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run8(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                       input logic cc, input logic [7:0] es, input logic eco);
      int j;
      @(negedge clk);
      a8 = aa; b8 = bb; ci8 = cc; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      j = 0;
      while (!done8 && j < 20) begin
         @(negedge clk);
         j++;
      end
      chk({tag, "_lat"}, j, 8);
      chk({tag, "_s"}, s8, es);
      chk({tag, "_co"}, co8, eco);
      chk({tag, "_busy"}, busy8, 0);
   endtask

   initial begin
      logic [7:0] s_tab, co_tab, dm, bm;
      int j, seen;
      s_tab  = 8'b1001_0110;
      co_tab = 8'b1110_1000;
      rst_n = 1'b0;
      start1 = 0; start8 = 0; start4 = 0;
      a1 = 0; b1 = 0; ci1 = 0; a8 = 0; b8 = 0; ci8 = 0; a4 = 0; b4 = 0; ci4 = 0;
`ifdef FA_SERIAL_SUB_EN
      sub1 = 0; sub8 = 0; sub4 = 0;
`endif
      #1;
      chk("rst_busy8", busy8, 0);
      chk("rst_done8", done8, 0);
      chk("rst_s8", s8, 0);
      chk("rst_co8", co8, 0);
      chk("rst_busy4", busy4, 0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      // WIDTH=1: all {ci,a,b}, one-cycle latency
      for (int v = 0; v < 8; v++) begin
         @(negedge clk);
         {ci1, a1, b1} = 3'(v);
         start1 = 1'b1;
         @(negedge clk);
         start1 = 1'b0;
         chk("w1_busy", busy1, 1);
         chk("w1_done_early", done1, 0);
         @(negedge clk);
         chk("w1_done", done1, 1);
         chk("w1_busy_at_done", busy1, 0);
         chk("w1_s", s1, s_tab[v]);
         chk("w1_co", co1, co_tab[v]);
      end

      run8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run8("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

      // start during RUN is ignored
      @(negedge clk);
      a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      j = 0;
      while (!done8 && j < 20) begin
         @(negedge clk);
         j++;
      end
      chk("ign_done", done8, 1);
      chk("ign_s", s8, 8'h46);
      chk("ign_co", co8, 0);
      repeat (2) @(negedge clk);
      chk("ign_no_done", done8, 0);
      chk("ign_idle", busy8, 0);
      chk("ign_hold_idle", s8, 8'h46);
      a8 = 8'h01; b8 = 8'h01; ci8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (2) @(negedge clk);
      chk("hold_run_busy", busy8, 1);
      chk("hold_run_s", s8, 8'h46);
      j = 0;
      while (!done8 && j < 20) begin
         @(negedge clk);
         j++;
      end
      chk("one_one_s", s8, 8'h02);

      // DIGIT=4: start held six cycles, operands disturbed mid-RUN
      @(negedge clk);
      a4 = 8'h3C; b4 = 8'h47; ci4 = 1'b1; start4 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         dm[k] = done4;
         bm[k] = busy4;
         if (done4) begin
            chk("d4_s", s4, 8'h84);
            chk("d4_co", co4, 0);
         end
         a4 = (k == 1 || k == 4) ? 8'hFF : 8'h3C;
         b4 = (k == 1 || k == 4) ? 8'hFF : 8'h47;
         start4 = (k < 5);
      end
      chk("d4_done_mask", dm, 8'b0010_0100);
      chk("d4_busy_mask", bm, 8'b0001_1011);

      // asynchronous reset mid-RUN
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", busy8, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy8, 0);
      chk("arst_done", done8, 0);
      chk("arst_s", s8, 0);
      chk("arst_co", co8, 0);
      chk("arst_s4", s4, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         seen += int'(done8);
      end
      chk("arst_no_done", seen, 0);
      run8("after_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

`ifdef FA_SERIAL_SUB_EN
      sub8 = 1'b1;
      run8("sub_10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
      run8("sub_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0);
      sub8 = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fa_serial_add.md
# fa_serial_add

Parametrised sequential adder: the multi-bit, clocked successor to the single-bit full-adder cells. It adds two WIDTH-bit operands plus a carry-in over WIDTH/DIGIT clock cycles, processing DIGIT bits per cycle, LSB first. A start/busy/done handshake wraps the computation. It serves as the area-lean arithmetic unit where a full-width combinational adder is not justified.

## Interface
- WIDTH, 8: operand and sum width in bits; must be ≥1.
- DIGIT, 1: bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise).
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled at a rising edge only when busy=0.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- ci  input  1  carry-in (borrow-in when subtracting); captured on the accepting edge.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse; s and co are valid from this cycle on.
- s  output  WIDTH  sum result register.
- co  output  1  carry-out of the MSB.

## Operation
- The block has three states: IDLE, RUN and DONE. K = WIDTH/DIGIT.
- IDLE, start=1: capture a, b and ci into internal shift registers and the carry register. Clear the digit counter. Go to RUN.
- RUN, each edge:
  - Add the low DIGIT bits of A, B and the carry.
  - Shift the DIGIT-bit result into the partial-sum register from the MSB end.
  - Shift A and B right by DIGIT.
  - Update the carry from bit DIGIT of the digit sum.
  - Increment the counter.
- On the K-th RUN edge: copy the partial sum to s and the final carry to co. Go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 on this edge: accepted as in IDLE, go to RUN (back-to-back operation).
  - Otherwise: go to IDLE.
- start while in RUN is ignored. It is not queued.
- s and co change only on the completing edge. They hold their value through later IDLE and RUN periods until the next completion.
- Arithmetic: {co, s} = a + b + ci, exact modulo 2^(WIDTH+1). No saturation.
- a, b and ci may change freely after the accepting edge without affecting the result.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, s=0, co=0. Internal registers and counter are cleared.
- Reset asserted mid-RUN aborts the operation. No done is produced. s and co read 0 after reset.
- Accepting edge E0: busy=1 from the cycle after E0.
- Completion edge is E0+K:
  - busy=0 and done=1 in the cycle following E0+K.
  - s and co are valid in that same cycle.
- Latency from start accepted to done: K cycles. For WIDTH=8, DIGIT=1 this is 8; for DIGIT=4 it is 2; for DIGIT=WIDTH it is 1.
- Back-to-back throughput: one result per K+1 cycles, with start held high.
- busy and done are never high in the same cycle.

## Configuration
- FA_SERIAL_SUB_EN defined:
  - Adds input port `sub` (1 bit), captured on the accepting edge.
  - sub=1: B is inverted digit-wise and the carry register is loaded with ~ci, giving {co, s} = a + ~b + ~ci, i.e. a − b − ci.
  - In subtract mode co=1 means no borrow.
  - sub=0: identical to the add-only block.
- FA_SERIAL_SUB_EN undefined: no `sub` port; add only.

## Test plan
- WIDTH=1, DIGIT=1, all 8 {ci,a,b} combinations:
  - s = a^b^ci and co = majority(a,b,ci).
  - done occurs 1 cycle after each accepted start.
- WIDTH=8, DIGIT=1, a=0xFF, b=0x01, ci=0: s=0x00, co=1, done exactly 8 cycles after the accepting edge. Then a=0xA5, b=0x5A, ci=1: s=0x00, co=1.
- WIDTH=8, DIGIT=4, a=0x3C, b=0x47, ci=1, start held high for 6 cycles:
  - s=0x84, co=0, done every 3 cycles.
  - Second result identical; a/b changes mid-RUN have no effect.
- Start pulse with new operands during RUN: ignored. The first result completes unchanged, and s holds it afterwards.
- rst_n pulsed low mid-RUN:
  - busy, done, s and co go to 0 immediately, with no clock required.
  - No done is produced.
  - A fresh start completes normally.
- FA_SERIAL_SUB_EN, WIDTH=8:
  - sub=1, a=0x10, b=0x01, ci=0 → s=0x0F, co=1.
  - sub=1, a=0x00, b=0x01, ci=0 → s=0xFF, co=0.
